// File: rtl/ss_addsub_sched.sv
// ss_addsub_sched
// Time-shares one SS_ADDSUB_CONT-style stochastic datapath between NREQ
// requesters. A job is: clear the datapath (CLEAR), let its buffer fill
// (WARM), accumulate the bipolar bitstream for STREAM_LEN cycles (RUN), then
// publish the signed count (FIN). Arbitration is round-robin starting after
// the last served/aborted requester.
//
// Ports
//   CLK      clock, rising edge
//   INIT     asynchronous active-high reset
//   REQ      per-requester job request (level)
//   ABORT    cancel the current job (CLEAR/WARM/RUN only)
//   DP_OUT   datapath stochastic output bit
//   DP_SIGN  datapath sign, 1 = negative
//   GNT      one-hot grant, held for the whole job
//   DP_INIT  datapath clear pulse (CLEAR state)
//   BUSY     high whenever not IDLE
//   DONE     one-cycle completion pulse (FIN state)
//   RESULT   signed bipolar count of the last completed job
module ss_addsub_sched #(
  parameter int NREQ       = 4,
  parameter int WARMUP     = 5,
  parameter int STREAM_LEN = 256,
  parameter int CW         = 10
) (
  input  logic                 CLK,
  input  logic                 INIT,
  input  logic [NREQ-1:0]      REQ,
  input  logic                 ABORT,
  input  logic                 DP_OUT,
  input  logic                 DP_SIGN,
  output logic [NREQ-1:0]      GNT,
  output logic                 DP_INIT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic signed [CW-1:0] RESULT
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (WARMUP > STREAM_LEN) ? WARMUP : STREAM_LEN;
  localparam int CNTW = $clog2(MAXC + 1);

  // The count is bounded by +/-STREAM_LEN, so this width can never wrap.
  if (CW < $clog2(STREAM_LEN) + 2) begin : g_cw_check
    $error("ss_addsub_sched: CW too small for STREAM_LEN");
  end

  typedef enum logic [2:0] {IDLE, CLEAR, WARM, RUN, FIN} state_t;

  state_t               state;
  logic [CNTW-1:0]      cnt;
  logic [IW-1:0]        last;
  logic [IW-1:0]        gidx;
  logic signed [CW-1:0] acc;

  // Round-robin pick: first requester at or after last+1, wrapping.
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_gnt;
  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && REQ[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    win_gnt = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
  end

  // Bipolar increment for this RUN cycle.
  logic signed [CW-1:0] delta;
  logic signed [CW-1:0] acc_next;
  always_comb begin
    delta = '0;
    if (DP_OUT) delta = DP_SIGN ? {CW{1'b1}} : CW'(1);
    acc_next = acc + delta;
  end

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= IW'(NREQ - 1);
      gidx    <= '0;
      acc     <= '0;
      GNT     <= '0;
      DP_INIT <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESULT  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // ABORT has no meaning here; a pending request always wins.
          if (|REQ) begin
            state   <= CLEAR;
            gidx    <= win_idx;
            GNT     <= win_gnt;
            DP_INIT <= 1'b1;
            BUSY    <= 1'b1;
            acc     <= '0;
          end
        end
        CLEAR, WARM, RUN: begin
          if (ABORT) begin
            state   <= IDLE;
            GNT     <= '0;
            DP_INIT <= 1'b0;
            BUSY    <= 1'b0;
            last    <= gidx;
          end else begin
            case (state)
              CLEAR: begin
                DP_INIT <= 1'b0;
                acc     <= '0;
                cnt     <= '0;
                state   <= (WARMUP == 0) ? RUN : WARM;
              end
              WARM: begin
                // DP_OUT is still settling; ignore it.
                if (cnt == CNTW'(WARMUP - 1)) begin
                  cnt   <= '0;
                  state <= RUN;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
              default: begin
                acc <= acc_next;
                if (cnt == CNTW'(STREAM_LEN - 1)) begin
                  // Include this cycle's bit in the published result.
                  RESULT <= acc_next;
                  DONE   <= 1'b1;
                  state  <= FIN;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
            endcase
          end
        end
        FIN: begin
          state <= IDLE;
          GNT   <= '0;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          last  <= gidx;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ss_addsub_sched.md
SS_ADDSUB_SCHED -- requirements
Module: SS_ADDSUB_SCHED

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters sharing one SS_ADDSUB_CONT-style datapath.
REQ-002 The block SHALL have parameter WARMUP, default 5: cycles after datapath clear before output sampling (buffer fill; equal to datapath DIFFCOUNTER_SIZE).
REQ-003 The block SHALL have parameter STREAM_LEN, default 256: bitstream length in cycles accumulated per job.
REQ-004 The block SHALL have parameter CW, default 10: signed result width; the block SHALL require CW >= clog2(STREAM_LEN)+2.
REQ-005 The block SHALL have port CLK, input, 1 bit: single clock, all state updates on rising edge.
REQ-006 The block SHALL have port INIT, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port REQ, input, NREQ bits: per-requester job request, level-sensitive.
REQ-008 The block SHALL have port ABORT, input, 1 bit: cancel the current job.
REQ-009 The block SHALL have port DP_OUT, input, 1 bit: datapath OUT stochastic bit.
REQ-010 The block SHALL have port DP_SIGN, input, 1 bit: datapath SIGN_out, 1 = negative.
REQ-011 The block SHALL have port GNT, output, NREQ bits: one-hot grant, held for the whole job.
REQ-012 The block SHALL have port DP_INIT, output, 1 bit: datapath clear pulse.
REQ-013 The block SHALL have port BUSY, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-015 The block SHALL have port RESULT, output, CW bits signed: accumulated bipolar count of the last completed job.

Function
REQ-016 The block SHALL implement five states: IDLE, CLEAR, WARM, RUN, FIN.
REQ-017 In IDLE with REQ nonzero, the block SHALL select the winner by round-robin, searching from index LAST+1 modulo NREQ, set GNT one-hot, and enter CLEAR on the next edge.
REQ-018 In IDLE with REQ zero, the block SHALL remain in IDLE with GNT = 0.
REQ-019 CLEAR SHALL last exactly 1 cycle; DP_INIT = 1 only in CLEAR; the accumulator SHALL be zeroed.
REQ-020 WARM SHALL last exactly WARMUP cycles; DP_OUT SHALL be ignored.
REQ-021 RUN SHALL last exactly STREAM_LEN cycles; each cycle acc <= acc + (DP_OUT ? (DP_SIGN ? -1 : +1) : 0).
REQ-022 The accumulator SHALL stay within +/-STREAM_LEN and therefore SHALL never wrap at legal CW.
REQ-023 FIN SHALL last 1 cycle, with RESULT <= final acc registered on entry, DONE = 1, and GNT still asserted.
REQ-024 After FIN, the block SHALL return to IDLE, clear GNT, and set LAST = granted index.
REQ-025 Latency from the IDLE sampling cycle (cycle 0) to DONE SHALL be WARMUP+STREAM_LEN+2 cycles.
REQ-026 The minimum job-to-job gap SHALL be 1 IDLE cycle.
REQ-027 Deassertion of REQ by the granted requester mid-job SHALL be ignored; the job completes.
REQ-028 ABORT in CLEAR, WARM or RUN SHALL return the block to IDLE on the next edge, with GNT = 0, no DONE, RESULT unchanged, and LAST = aborted index.
REQ-029 ABORT in IDLE or FIN SHALL be ignored.
REQ-030 Simultaneous requests SHALL never produce more than one GNT bit, and no requester SHALL wait more than NREQ-1 jobs.

Reset
REQ-031 While INIT = 1, the block SHALL immediately force state IDLE, GNT = 0, DP_INIT = 0, BUSY = 0, DONE = 0, RESULT = 0, acc = 0, and LAST = NREQ-1, so the first grant goes to index 0 priority.
REQ-032 INIT asserted mid-job SHALL discard the job with no DONE.

Verification (NREQ=4, WARMUP=5, STREAM_LEN=16, CW=6)
REQ-033 The bench SHALL cover: REQ=0001, DP_OUT=1, DP_SIGN=0 -> GNT=0001, DP_INIT high at cycle 1, DONE at cycle 23, RESULT=+16.
REQ-034 The bench SHALL cover: REQ=0100, DP_OUT alternating 1/0 with DP_SIGN=1 during RUN -> RESULT=-8; DP_OUT activity during WARM does not change RESULT.
REQ-035 The bench SHALL cover: REQ=1111 held for 4 jobs -> grant order 0001, 0010, 0100, 1000, with each GNT one-hot and BUSY low for exactly 1 cycle between jobs.
REQ-036 The bench SHALL cover: ABORT pulsed in RUN cycle 10 -> IDLE next edge, no DONE, RESULT keeps prior value, next grant goes to the following index.
REQ-037 The bench SHALL cover: INIT pulsed asynchronously mid-WARM -> outputs zero before the next CLK edge; the first post-reset grant with REQ=1111 goes to 0001.
